// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw PS/2 lines, deserialises
// 11-bit frames, folds E0/F0 prefixes into flags and publishes a toggling 11-bit key event.
// Receive-only: the PS/2 lines are never driven.
module ps2_key_rx #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_strobe,
   output logic        frame_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } state_e;

   state_e        state_q;

   logic          clk_meta_q;
   logic          clk_sync_q;
   logic          data_meta_q;
   logic          data_sync_q;

   logic          filt_q;
   logic          filt_prev_q;
   logic [7:0]    fcnt_q;

   logic [TW-1:0] idle_cnt_q;
   logic          busy;
   logic          fall;
   logic          tmo;

   logic [7:0]    sr_q;
   logic          par_q;
   logic [2:0]    bitcnt_q;
   logic          ext_q;
   logic          brk_q;

   logic          frame_ok;

   // Two-flop synchronisers; lines idle high so they reset to 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   // Clock filter: level follows the synchronised clock only after FILTER_LEN
   // consecutive differing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= 8'd0;
      end else begin
         filt_prev_q <= filt_q;
         if (clk_sync_q == filt_q) begin
            fcnt_q <= 8'd0;
         end else if (fcnt_q == 8'(FILTER_LEN - 1)) begin
            filt_q <= clk_sync_q;
            fcnt_q <= 8'd0;
         end else begin
            fcnt_q <= fcnt_q + 8'd1;
         end
      end
   end

   // Edge and timeout qualifiers; a falling edge always beats a timeout.
   always_comb begin
      fall     = filt_prev_q & ~filt_q;
      busy     = (state_q != StIdle);
      tmo      = busy && !fall && (idle_cnt_q == TW'(TIMEOUT - 1));
      frame_ok = data_sync_q && (^{sr_q, par_q});
   end

   // Mid-frame idle counter, cleared by every falling edge and while idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt_q <= '0;
      end else if (!busy || fall) begin
         idle_cnt_q <= '0;
      end else if (idle_cnt_q != TW'(TIMEOUT - 1)) begin
         idle_cnt_q <= idle_cnt_q + TW'(1);
      end
   end

   // Frame FSM with registered outputs and prefix folding.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         sr_q       <= 8'd0;
         par_q      <= 1'b0;
         bitcnt_q   <= 3'd0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         ps2_key    <= 11'h000;
         key_strobe <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         frame_err  <= 1'b0;
         if (tmo) begin
            frame_err <= 1'b1;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            state_q   <= StIdle;
         end else if (fall) begin
            unique case (state_q)
               StIdle: begin
                  if (!data_sync_q) begin
                     bitcnt_q <= 3'd0;
                     state_q  <= StData;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               StData: begin
                  sr_q     <= {data_sync_q, sr_q[7:1]};
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     state_q <= StParity;
                  end
               end
               StParity: begin
                  par_q   <= data_sync_q;
                  state_q <= StStop;
               end
               StStop: begin
                  state_q <= StIdle;
                  if (!frame_ok) begin
                     frame_err <= 1'b1;
                     ext_q     <= 1'b0;
                     brk_q     <= 1'b0;
                  end else if (sr_q == 8'hE0) begin
                     ext_q <= 1'b1;
                  end else if (sr_q == 8'hF0) begin
                     brk_q <= 1'b1;
                  end else begin
                     ps2_key    <= {~ps2_key[10], ~brk_q, ext_q, sr_q};
                     key_strobe <= 1'b1;
                     ext_q      <= 1'b0;
                     brk_q      <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: table of frames with hand-computed key words plus
// hand-written sequences for latency, timeout, glitch, start error and async reset.
module tb_ps2_key_rx;

   localparam int unsigned FL  = 4;
   localparam int unsigned TMO = 200;
   localparam int          H   = 20;   // PS/2 half period in clk cycles

   logic        clk;
   logic        reset_n;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        frame_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_strobe = 0;
   int n_err    = 0;

   typedef struct packed {
      logic [7:0]  code;
      logic        par_ok;
      logic [10:0] key;
      logic [1:0]  strobes;
      logic [1:0]  errs;
   } vec_t;

   vec_t vecs [12];

   ps2_key_rx #(
      .FILTER_LEN (FL),
      .TIMEOUT    (TMO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (key_strobe) n_strobe++;
      if (frame_err)  n_err++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         tick(8);
         ps2_clk = 1'b0;
         tick(3);
         ps2_clk = 1'b1;
         tick(H - 11);
      end else begin
         tick(H);
      end
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input bit par_ok, input bit glitch);
      logic par;
      par = par_ok ? ~(^code) : ^code;
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
      send_bit(par, glitch);
      send_bit(1'b1, glitch);
      ps2_data = 1'b1;
      tick(H);
   endtask

   initial begin
      int s0;
      int e0;
      int w;
      logic [7:0] b45;
      logic [7:0] b74;
      logic [7:0] b72;

      vecs[0]  = '{8'hE0, 1'b1, 11'h672, 2'd0, 2'd0};
      vecs[1]  = '{8'hF0, 1'b1, 11'h672, 2'd0, 2'd0};
      vecs[2]  = '{8'h75, 1'b1, 11'h175, 2'd1, 2'd0};
      vecs[3]  = '{8'h16, 1'b0, 11'h175, 2'd0, 2'd1};
      vecs[4]  = '{8'h1E, 1'b1, 11'h61E, 2'd1, 2'd0};
      vecs[5]  = '{8'hF0, 1'b1, 11'h61E, 2'd0, 2'd0};
      vecs[6]  = '{8'hE0, 1'b1, 11'h61E, 2'd0, 2'd0};
      vecs[7]  = '{8'h5A, 1'b1, 11'h15A, 2'd1, 2'd0};
      vecs[8]  = '{8'hE1, 1'b1, 11'h6E1, 2'd1, 2'd0};
      vecs[9]  = '{8'hE0, 1'b1, 11'h6E1, 2'd0, 2'd0};
      vecs[10] = '{8'h22, 1'b0, 11'h6E1, 2'd0, 2'd1};
      vecs[11] = '{8'h22, 1'b1, 11'h222, 2'd1, 2'd0};

      reset_n  = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(5);
      check("reset key", int'(ps2_key), 0);
      check("reset strobe", int'(key_strobe), 0);
      check("reset err", int'(frame_err), 0);
      reset_n = 1'b1;
      tick(5);

      // Single make with exact latency on the stop-bit edge.
      b72 = 8'h72;
      s0  = n_strobe;
      e0  = n_err;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b72[i], 1'b0);
      send_bit(~(^b72), 1'b0);
      ps2_data = 1'b1;
      tick(H);
      ps2_clk = 1'b0;
      tick(2 + FL);
      check("latency early key", int'(ps2_key), 0);
      check("latency early strobe", int'(key_strobe), 0);
      tick(1);
      check("latency key", int'(ps2_key), 'h672);
      check("latency strobe", int'(key_strobe), 1);
      tick(H - 3 - FL);
      ps2_clk = 1'b1;
      tick(H);
      check("make strobe count", n_strobe - s0, 1);
      check("make err count", n_err - e0, 0);

      for (int v = 0; v < 12; v++) begin
         s0 = n_strobe;
         e0 = n_err;
         send_frame(vecs[v].code, vecs[v].par_ok, 1'b0);
         check($sformatf("vec%0d key", v), int'(ps2_key), int'(vecs[v].key));
         check($sformatf("vec%0d strobes", v), n_strobe - s0, int'(vecs[v].strobes));
         check($sformatf("vec%0d errs", v), n_err - e0, int'(vecs[v].errs));
      end

      // Start error: falling edge with data high while idle.
      e0 = n_err;
      send_bit(1'b1, 1'b0);
      tick(H);
      check("start err", n_err - e0, 1);
      check("start err key", int'(ps2_key), 'h222);

      // Timeout after start + 4 data bits, then a clean frame.
      b45 = 8'h45;
      e0  = n_err;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(b45[i], 1'b0);
      w = 0;
      while (w < 2 * TMO && n_err == e0) begin
         tick(1);
         w++;
      end
      check("timeout err", n_err - e0, 1);
      check("timeout delay window", int'(w >= 150 && w <= 220), 1);
      check("timeout key", int'(ps2_key), 'h222);
      tick(H);
      s0 = n_strobe;
      send_frame(8'h45, 1'b1, 1'b0);
      check("post-timeout key", int'(ps2_key), 'h645);
      check("post-timeout strobes", n_strobe - s0, 1);

      // Glitch rejection.
      s0 = n_strobe;
      e0 = n_err;
      send_frame(8'h6B, 1'b1, 1'b1);
      check("glitch key", int'(ps2_key), 'h26B);
      check("glitch strobes", n_strobe - s0, 1);
      check("glitch errs", n_err - e0, 0);

      // Async reset mid-frame after an E0 prefix.
      b74 = 8'h74;
      send_frame(8'hE0, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(b74[i], 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("async reset key", int'(ps2_key), 0);
      check("async reset strobe", int'(key_strobe), 0);
      tick(3);
      reset_n = 1'b1;
      tick(5);
      s0 = n_strobe;
      e0 = n_err;
      send_frame(8'h74, 1'b1, 1'b0);
      check("after reset key", int'(ps2_key), 'h674);
      check("after reset strobes", n_strobe - s0, 1);
      check("after reset errs", n_err - e0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
